// File: rtl/seg_scan_driver.sv
// Self-timed multiplexing driver for common-anode 7-segment banks.
// Frame-latched shadow data, per-slot dead-time blanking and frame-counted blink.
module seg_scan_driver #(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned DEAD         = 4,
  parameter int unsigned BLINK_FRAMES = 64,
  localparam int unsigned SW          = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     les,
  output logic [3:0]            hexo,
  output logic                  p,
  output logic                  le,
  output logic [DIGITS-1:0]     an,
  output logic [SW-1:0]         scan,
  output logic                  frame_tick
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic                  ph_q, ph_d;
  logic                  tick_q, tick_d;
  logic [4*DIGITS-1:0]   hex_q, hex_d;
  logic [DIGITS-1:0]     pt_q, pt_d;
  logic [DIGITS-1:0]     le_q, le_d;

  logic cnt_last, idx_last, fcnt_last, boundary, blank;

  assign cnt_last  = (cnt_q == CW'(PRESCALE - 1));
  assign idx_last  = (idx_q == SW'(DIGITS - 1));
  assign fcnt_last = (fcnt_q == FW'(BLINK_FRAMES - 1));
  assign boundary  = cnt_last && idx_last;

  always_comb begin
    cnt_d  = cnt_last ? '0 : cnt_q + CW'(1);
    idx_d  = idx_q;
    fcnt_d = fcnt_q;
    ph_d   = ph_q;
    tick_d = 1'b0;
    hex_d  = hex_q;
    pt_d   = pt_q;
    le_d   = le_q;
    if (cnt_last) begin
      idx_d = idx_last ? '0 : idx_q + SW'(1);
    end
    // Shadows only reload here, so a frame never shows mixed old/new data.
    if (boundary) begin
      hex_d  = hexs;
      pt_d   = points;
      le_d   = les;
      tick_d = 1'b1;
      if (fcnt_last) begin
        fcnt_d = '0;
        ph_d   = ~ph_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      fcnt_q <= '0;
      ph_q   <= 1'b0;
      tick_q <= 1'b0;
      hex_q  <= '0;
      pt_q   <= '0;
      le_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      fcnt_q <= fcnt_d;
      ph_q   <= ph_d;
      tick_q <= tick_d;
      hex_q  <= hex_d;
      pt_q   <= pt_d;
      le_q   <= le_d;
    end
  end

  always_comb begin
    hexo       = hex_q[4*int'(idx_q) +: 4];
    p          = pt_q[idx_q];
    le         = le_q[idx_q];
    scan       = idx_q;
    frame_tick = tick_q;
    blank      = (int'(cnt_q) < int'(DEAD)) || (ph_q && le_q[idx_q]);
    an         = blank ? '1 : ~(DIGITS'(1) << idx_q);
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver: outputs are predicted from the elapsed
// cycle count since reset and the inputs captured at each frame boundary.
module tb_seg_scan_driver;

  localparam int D  = 4;
  localparam int PS = 4;
  localparam int DT = 1;
  localparam int BF = 2;
  localparam int FRAME = D * PS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  les;
  logic [3:0]  hexo;
  logic        p;
  logic        le;
  logic [3:0]  an;
  logic [1:0]  scan;
  logic        frame_tick;

  seg_scan_driver #(
    .DIGITS      (D),
    .PRESCALE    (PS),
    .DEAD        (DT),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hexs      (hexs),
    .points    (points),
    .les       (les),
    .hexo      (hexo),
    .p         (p),
    .le        (le),
    .an        (an),
    .scan      (scan),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: edges since reset release, boundaries seen, captured data.
  int          k;
  int          nb;
  logic [15:0] sh_hex;
  logic [3:0]  sh_pt;
  logic [3:0]  sh_le;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, frames %0d)", tag, obs, exp, k, nb);
    end
  endtask

  task automatic model_reset();
    k      = 0;
    nb     = 0;
    sh_hex = '0;
    sh_pt  = '0;
    sh_le  = '0;
  endtask

  task automatic check_outputs();
    int         slot;
    int         pos;
    int         ph;
    bit         blank;
    logic [3:0] an_e;
    logic [3:0] onehot;
    slot   = (k / PS) % D;
    pos    = k % PS;
    ph     = (nb / BF) % 2;
    blank  = (pos < DT) || (ph == 1 && sh_le[slot]);
    onehot = 4'(1 << slot);
    an_e   = blank ? 4'hF : ~onehot;
    check_eq("hexo", 32'(hexo), 32'(sh_hex[slot*4 +: 4]));
    check_eq("p", 32'(p), 32'(sh_pt[slot]));
    check_eq("le", 32'(le), 32'(sh_le[slot]));
    check_eq("an", 32'(an), 32'(an_e));
    check_eq("scan", 32'(scan), 32'(slot));
    check_eq("frame_tick", 32'(frame_tick), 32'(k > 0 && k % FRAME == 0));
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    @(posedge clk);
    #1 check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    hexs   = 16'h4321;
    points = 4'b0101;
    les    = 4'b0010;
    model_reset();
    #12 check_outputs();
    @(negedge clk);
    rst = 1'b0;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk);
      #1;
      k++;
      if (k % FRAME == 0) begin
        nb++;
        sh_hex = hexs;
        sh_pt  = points;
        sh_le  = les;
      end
      check_outputs();
      @(negedge clk);
      // Edge 99 lies in frame 6, i.e. blink-off phase, for the forced reset.
      if (cyc == 99 || cyc == 1300 || $urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 5) == 0) hexs = 16'($urandom);
        if ($urandom_range(0, 9) == 0) points = 4'($urandom);
        if ($urandom_range(0, 19) == 0) les = 4'($urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
